// File: rtl/enc_layer_seq.sv
// Sequencer for a time-multiplexed y = W*x + b layer driving one shared MAC/accumulator.
// Optional cycle_cnt performance counter is built when ENC_LAYER_SEQ_PERF_EN is defined.
module enc_layer_seq #(
    parameter int ROWS = 6,
    parameter int COLS = 10,
    parameter int WA_W = $clog2(ROWS * COLS),
    parameter int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CI_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op_valid,
    input  logic            y_ready,
    output logic [WA_W-1:0] w_addr,
    output logic [CI_W-1:0] x_idx,
    output logic [RI_W-1:0] b_idx,
    output logic [RI_W-1:0] y_idx,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            bias_en,
    output logic            y_wr,
    output logic            busy,
`ifdef ENC_LAYER_SEQ_PERF_EN
    output logic [15:0]     cycle_cnt,
`endif
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_BIAS,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [CI_W-1:0] COL_LAST = CI_W'(COLS - 1);
    localparam logic [RI_W-1:0] ROW_LAST = RI_W'(ROWS - 1);

    state_e          state_q, state_d;
    logic [RI_W-1:0] row_q, row_d;
    logic [CI_W-1:0] col_q, col_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        bias_en = 1'b0;
        y_wr    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_CLEAR;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_CLEAR: begin
                acc_clr = 1'b1;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_en = 1'b1;
                // Without a valid operand the indices hold so the datapath retries the same column.
                if (op_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = S_BIAS;
                    end else begin
                        col_d = col_q + CI_W'(1);
                    end
                end
            end
            S_BIAS: begin
                bias_en = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                y_wr = 1'b1;
                if (y_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + RI_W'(1);
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // Row/col are zero outside a pass, so the indices read 0 in IDLE without extra gating.
    assign w_addr = WA_W'(int'(row_q) * COLS + int'(col_q));
    assign x_idx  = col_q;
    assign b_idx  = row_q;
    assign y_idx  = row_q;

`ifdef ENC_LAYER_SEQ_PERF_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (start) cnt_d = '0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cycle_cnt = cnt_q;
`else
    // No performance counter in this build.
`endif

endmodule

// File: tb/tb_enc_layer_seq.sv
// Scoreboard bench for enc_layer_seq: the driver queues expected weight/row/done events,
// a negedge monitor pops and compares them whenever the DUT presents a strobe.
module tb_enc_layer_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       op_valid = 1'b1;
    logic       y_ready = 1'b1;
    logic [5:0] w_addr;
    logic [3:0] x_idx;
    logic [2:0] b_idx, y_idx;
    logic       acc_clr, acc_en, bias_en, y_wr, busy, done;
`ifdef ENC_LAYER_SEQ_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    enc_layer_seq dut (
        .clk(clk), .reset(reset), .start(start), .op_valid(op_valid), .y_ready(y_ready),
        .w_addr(w_addr), .x_idx(x_idx), .b_idx(b_idx), .y_idx(y_idx),
        .acc_clr(acc_clr), .acc_en(acc_en), .bias_en(bias_en), .y_wr(y_wr),
        .busy(busy),
`ifdef ENC_LAYER_SEQ_PERF_EN
        .cycle_cnt(cycle_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit done_seen = 1'b0;
    int wq[$];
    int yq[$];
    int dq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc - base);
    endtask

    // Monitor: every checkable event is compared against the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            chk("strobe_onehot", $countones({acc_clr, acc_en, bias_en, y_wr}),
                (busy && !done) ? 1 : 0);
            if (acc_en) begin
                if (wq.size() == 0) unexpected("w_extra");
                else begin
                    chk("w_addr", int'(w_addr), wq[0]);
                    chk("x_idx", int'(x_idx), wq[0] % 10);
                    if (op_valid) void'(wq.pop_front());
                end
            end
            if (bias_en) begin
                if (yq.size() == 0) unexpected("bias_extra");
                else chk("b_idx", int'(b_idx), yq[0]);
            end
            if (y_wr) begin
                if (yq.size() == 0) unexpected("y_extra");
                else begin
                    chk("y_idx", int'(y_idx), yq[0]);
                    if (y_ready) void'(yq.pop_front());
                end
            end
            if (done) begin
                if (dq.size() == 0) unexpected("done_extra");
                else chk("done_cycle", cyc - base, dq.pop_front());
                done_seen = 1'b1;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_strobes"}, int'({acc_clr, acc_en, bias_en, y_wr}), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_x_idx"}, int'(x_idx), 0);
        chk({tag, "_b_y_idx"}, int'({b_idx, y_idx}), 0);
    endtask

    // One layer pass. Stall windows and extra start pulses are given in pass cycle numbers
    // (cycle 1 = first cycle after the edge that samples start). abort_at != 0 resets mid-pass.
    task automatic run_pass(input int ov_at, input int ov_n, input int yr_at, input int yr_n,
                            input int s2, input int s3, input int s4, input int abort_at,
                            input int exp_done);
        int cur;
        for (int r = 0; r < 6; r++) yq.push_back(r);
        for (int i = 0; i < 60; i++) wq.push_back(i);
        if (abort_at == 0) dq.push_back(exp_done);
        done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = cyc - 1;
        for (int k = 0; k < 400 && !done_seen; k++) begin
            cur = cyc - base;
            op_valid = !(cur >= ov_at && cur < ov_at + ov_n);
            y_ready  = !(cur >= yr_at && cur < yr_at + yr_n);
            start    = (cur == s2) || (cur == s3) || (cur == s4);
            if (abort_at != 0 && cur == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                chk_all_zero("abort");
                wq.delete();
                yq.delete();
                start = 1'b0;
                op_valid = 1'b1;
                y_ready = 1'b1;
                @(negedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        op_valid = 1'b1;
        y_ready = 1'b1;
        if (!done_seen) unexpected("done_timeout");
        chk("busy_after_done", int'(busy), 0);
        chk("w_left", wq.size(), 0);
        chk("y_left", yq.size(), 0);
`ifdef ENC_LAYER_SEQ_PERF_EN
        chk("cycle_cnt", int'(cycle_cnt), exp_done);
`endif
        @(posedge clk);
        #1;
        chk("busy_stays_idle", int'(busy), 0);
        wq.delete();
        yq.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("idle");

        run_pass(0, 0, 0, 0, 0, 0, 0, 0, 79);     // plain pass
        run_pass(32, 3, 0, 0, 0, 0, 0, 0, 82);    // op stall at row 2, col 4
        run_pass(0, 0, 78, 5, 0, 0, 0, 0, 84);    // write backpressure at row 5
        run_pass(0, 0, 0, 0, 10, 40, 79, 0, 79);  // start pulses while busy / in DONE
        run_pass(0, 0, 0, 0, 0, 0, 0, 45, 0);     // reset mid-MAC at row 3
        run_pass(0, 0, 0, 0, 0, 0, 0, 0, 79);     // fresh pass after abort

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enc_layer_seq.md
Name: enc_layer_seq

Overview:
- Sequencer for a time-multiplexed encoder layer computing y = W·x + b on a single shared MAC/accumulator datapath.
- Replaces the fully parallel matrix-vector block when area matters. The block walks rows and columns, generates weight, input and bias indices, and drives the accumulator clear/enable/bias/write strobes.
- Sits between the layer-level control (start/done) and the MAC datapath plus output buffer.

Parameters:
- ROWS, 6, output neurons (rows of W, entries of b and y).
- COLS, 10, input vector length (columns of W).
- WA_W, $clog2(ROWS*COLS), weight address width.
- RI_W, $clog2(ROWS) (min 1), row index width.
- CI_W, $clog2(COLS) (min 1), column index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle request to run one layer pass; sampled in IDLE only.
- op_valid  in  1  W/x operands for current w_addr/x_idx are valid this cycle.
- y_ready  in  1  output buffer accepts the write this cycle.
- w_addr  out  WA_W  weight index = row*COLS + col.
- x_idx  out  CI_W  input vector index = col.
- b_idx  out  RI_W  bias index = row.
- y_idx  out  RI_W  output index = row.
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate; datapath adds only when acc_en & op_valid.
- bias_en  out  1  add b[b_idx] to accumulator.
- y_wr  out  1  write accumulator to y[y_idx]; transfer occurs when y_wr & y_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Moore FSM. All outputs decode from registered state/row/col only; there is no combinational input-to-output path.
- States: IDLE, CLEAR, MAC, BIAS, WRITE, DONE.
- Reset (reset=0, async): state=IDLE, row=0, col=0. All strobes, busy and done = 0. w_addr/x_idx/b_idx/y_idx = 0.
- IDLE: start=1 -> CLEAR with row=0, col=0. start=0 -> stay in IDLE.
- CLEAR: acc_clr=1 for one cycle -> MAC.
- MAC: acc_en=1, w_addr=row*COLS+col, x_idx=col.
  - op_valid=0: hold state and indices (stall).
  - op_valid=1 and col<COLS-1: col+1.
  - op_valid=1 and col=COLS-1: col=0 -> BIAS.
- BIAS: bias_en=1, b_idx=row, one cycle -> WRITE.
- WRITE: y_wr=1, y_idx=row.
  - y_ready=0: hold.
  - y_ready=1 and row<ROWS-1: row+1 -> CLEAR.
  - y_ready=1 and row=ROWS-1: -> DONE.
- DONE: done=1, busy=1 for one cycle -> IDLE with row=0, col=0.
- Exactly one of acc_clr/acc_en/bias_en/y_wr is high in any cycle. None are high in IDLE or DONE.
- Latency with op_valid=1 and y_ready=1 throughout: each row takes COLS+3 cycles. If start is sampled at edge 0, done is high in cycle ROWS*(COLS+3)+1, which is cycle 79 for the defaults.
- Each stall cycle (op_valid=0 in MAC, or y_ready=0 in WRITE) adds exactly one cycle.
- start while busy=1 is ignored; it is not queued.
- start arriving in the same cycle as done (DONE state) is ignored. A new pass requires start in IDLE.
- Index arithmetic is unsigned. w_addr never exceeds ROWS*COLS-1. Counters wrap to 0 only via the transitions above, never by overflow.
- Reset asserted mid-pass aborts immediately to the reset values. No done pulse is produced. The partial y contents are undefined.

Optional Feature:
- Macro ENC_LAYER_SEQ_PERF_EN.
- Defined:
  - Adds output port cycle_cnt [15:0].
  - Cleared to 0 on reset and in the cycle start is accepted.
  - Increments by 1 every cycle busy=1, saturating at 16'hFFFF.
  - Holds its value in IDLE, so it reads the total pass cycles including DONE. Defaults with no stalls give 79.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then start=1 for one cycle with op_valid=1 and y_ready=1 -> done pulses in cycle 79. The sequence shows w_addr 0..59 in order and y_wr exactly 6 times with y_idx 0..5. busy is high in cycles 1..79.
- Mid-row stall: op_valid=0 for 3 cycles at row 2, col 4 -> w_addr holds at 24 for 4 cycles and col does not advance. done moves to cycle 82.
- Output backpressure: y_ready=0 for 5 cycles at row 5 WRITE -> y_wr and y_idx=5 hold. done moves to cycle 84. No extra write occurs.
- start pulsed at cycles 10, 40 and 79 during a pass -> a single pass only. busy=0 in cycle 80 and the FSM stays in IDLE.
- Drive reset=0 asynchronously mid-MAC at row 3 -> all outputs 0 and state IDLE before the next edge. A fresh start then gives done in cycle 79.
- With ENC_LAYER_SEQ_PERF_EN defined and no stalls -> cycle_cnt=79 after done. With 3 op_valid stall cycles -> 82.
